// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle MIPS-style datapath.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               zero,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               iord,
  output logic               alusrca,
  output logic               regdst,
  output logic               memtoreg,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [1:0]         aluop,
  output logic               pcen,
  output logic [STATE_W-1:0] state
);
  localparam logic [STATE_W-1:0] FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] MEMRD    = STATE_W'(3);
  localparam logic [STATE_W-1:0] MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] MEMWR    = STATE_W'(5);
  localparam logic [STATE_W-1:0] EXECUTE  = STATE_W'(6);
  localparam logic [STATE_W-1:0] ALUWB    = STATE_W'(7);
  localparam logic [STATE_W-1:0] BRANCH   = STATE_W'(8);
  localparam logic [STATE_W-1:0] ADDIEXEC = STATE_W'(9);
  localparam logic [STATE_W-1:0] ADDIWB   = STATE_W'(10);
  localparam logic [STATE_W-1:0] JUMP     = STATE_W'(11);
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  logic [STATE_W-1:0] state_q, state_d, dec_s;
  logic               pcwrite, branch;
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE:   state_d = (op == OP_LW || op == OP_SW) ? MEMADR :
                          (op == OP_RT)   ? EXECUTE  :
                          (op == OP_BEQ)  ? BRANCH   :
                          (op == OP_ADDI) ? ADDIEXEC :
                          (op == OP_J)    ? JUMP     : FETCH;
      MEMADR:   state_d = (op == OP_LW) ? MEMRD : (op == OP_SW) ? MEMWR : FETCH;
      MEMRD:    state_d = MEMWB;
      EXECUTE:  state_d = ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? FETCH : state_d;
  end
  // Reset presents FETCH selects so the datapath sees a sane fetch setup.
  assign dec_s = reset ? FETCH : state_q;
  always_comb begin
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    alusrca  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (dec_s)
      FETCH: begin
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      DECODE:   alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:    iord = 1'b1;
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:   regwrite = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
    end
  end
  assign pcen  = pcwrite | (branch & zero);
  assign state = state_q;
endmodule
